reg_src_sequencer: RTL and testbench
====================================

# reg_src_sequencer

Multi-cycle control FSM that drives the 3-bit select of the RegSrc mux and the register-file write port (write enable and destination) for register-initialisation macro-ops. It sits between the instruction decoder and the RegSrc mux / register file. A single Start command expands into a fixed sequence of one-register-per-cycle writes, each choosing either the datapath value or a hard-wired constant. A Start/Ready/Busy/Done handshake with the decoder, plus a Hold stall input, controls each sequence.

## Interface
- No parameters. Fixed: 8 architectural registers, 3-bit mux select.
- Clock  in  1  rising-edge clock for all state.
- Reset_n  in  1  asynchronous, active-low reset. Clears all state immediately.
- Start  in  1  command strobe; sampled only while Ready=1.
- Op  in  2  macro-op code; latched when Start is accepted.
- Dest  in  3  destination register for MOVE; latched when Start is accepted.
- Hold  in  1  pipeline stall; freezes the sequence.
- Selection  out  3  RegSrc mux select, registered.
- RegWrite  out  1  register-file write enable.
- WriteReg  out  3  register-file write address, registered.
- Ready  out  1  high in IDLE only.
- Busy  out  1  high in RUN only.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  sticky illegal-op flag. Exists only when REGSRC_SEQ_ERR_EN is defined.

## Operation
- Select encoding driven on Selection:
  - 0: datapath input
  - 1: const 0
  - 2: const 1
  - 3: const 3
  - 4: const 6
  - 5: const 7
  - 6: const 2
  - 7: reserved, never driven.
- States: IDLE, RUN, DONE.
  - IDLE → RUN on Start=1. Latch Op and Dest, reset the step counter to 0.
  - RUN → DONE after the final step's write completes.
  - DONE → IDLE unconditionally after one cycle.
- Macro-ops, as steps of (WriteReg, Selection):
  - Op 0 ZERO_ALL: 7 steps, (1,1) (2,1) … (7,1). R0 is never written.
  - Op 1 LOAD_CONSTS: 5 steps, (1,2) (2,6) (3,3) (6,4) (7,5).
  - Op 2 MOVE: 1 step, (latched Dest, 0).
  - Op 3: illegal; see Configuration.
- Step counter: 3 bits. It advances only on cycles in RUN with Hold=0.
- RegWrite = RUN & ~Hold. This is the only combinational output.
  - While Hold=1, the current step repeats and no write occurs.
- Start, Op and Dest are ignored outside IDLE. There is no queueing.
- Outputs in IDLE and DONE: Selection=0, WriteReg=0, RegWrite=0.
- Reset values of all outputs, and on any Reset_n assertion:
  - Selection=0, WriteReg=0, RegWrite=0, Busy=0, Done=0, Err=0.
  - Ready=1 once reset is released.
  - State = IDLE.
- Reset mid-sequence abandons the sequence: no Done, and no further writes.

## Timing
- Start accepted at edge N. Step k (k=0..L-1) is presented during cycle N+1+k, with no Hold.
- Each held cycle adds one cycle of latency.
- Done = 1 in cycle N+1+L, and Ready = 1 again in cycle N+2+L.
  - Command-to-command minimum spacing is L+2 cycles.
- Hold asserted in the same cycle as the final step: the final write is delayed; Done follows the first un-held final-step cycle.
- Hold has no effect in IDLE or DONE.
- Start held high continuously is re-accepted at each IDLE cycle.
- Reset_n deassertion is not required to be glitch-free. Release is synchronised externally.

## Configuration
- Macro REGSRC_SEQ_ERR_EN.
- Defined:
  - Op 3 enters DONE directly from IDLE with no writes, so Done pulses in cycle N+1.
  - Err sets in cycle N+1 and stays set until Reset_n.
- Undefined:
  - The Err port is absent.
  - Op 3 behaves as a 1-step no-write sequence: RegWrite stays 0 and Done pulses in cycle N+2.

## Test plan
- Reset mid-ZERO_ALL (step 3) → outputs drop to reset values asynchronously, no Done, and the next Start after release runs from step 0.
- Op=1 Start at cycle 10, Hold=0 → writes observed in this order:
  - cycle 11: WriteReg 1, Sel 2
  - cycle 12: WriteReg 2, Sel 6
  - cycle 13: WriteReg 3, Sel 3
  - cycle 14: WriteReg 6, Sel 4
  - cycle 15: WriteReg 7, Sel 5
  - cycle 16: Done
  - cycle 17: Ready
- Op=2, Dest=5, with Dest changed to 2 in cycle N+1 → a single write with WriteReg=5, Sel=0, Busy for 1 cycle.
- Op=0 with Hold high for 2 cycles at step 4 → RegWrite=0 while held, WriteReg=5 presented for 3 cycles, 7 writes total, Done 2 cycles late.
- Start pulses during Busy and during DONE → ignored, and the sequence is unchanged.
- Op=3 with REGSRC_SEQ_ERR_EN defined → no RegWrite, Done at N+1, Err stays 1 through subsequent legal ops.
  - Without the macro → no writes and Done at N+2.

Source files
------------

// File: rtl/reg_src_sequencer.sv
// reg_src_sequencer: expands a single Start command into a fixed series of
// one-register-per-cycle register-file writes, steering the RegSrc mux select
// for each write. Start/Ready/Busy/Done handshake with the decoder; Hold
// freezes the running sequence.
// Optional feature: define REGSRC_SEQ_ERR_EN to add the sticky Err output and
// short-circuit the illegal op straight to DONE.
module reg_src_sequencer (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [1:0] Op,
  input  logic [2:0] Dest,
  input  logic       Hold,
  output logic [2:0] Selection,
  output logic       RegWrite,
  output logic [2:0] WriteReg,
  output logic       Ready,
  output logic       Busy,
  output logic       Done
`ifdef REGSRC_SEQ_ERR_EN
  ,
  output logic       Err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ZERO_ALL    = 2'd0,
    OP_LOAD_CONSTS = 2'd1,
    OP_MOVE        = 2'd2,
    OP_ILLEGAL     = 2'd3
  } op_t;

  // RegSrc mux select codes
  localparam logic [2:0] SEL_DATAPATH = 3'd0;
  localparam logic [2:0] SEL_C0       = 3'd1;
  localparam logic [2:0] SEL_C1       = 3'd2;
  localparam logic [2:0] SEL_C3       = 3'd3;
  localparam logic [2:0] SEL_C6       = 3'd4;
  localparam logic [2:0] SEL_C7       = 3'd5;
  localparam logic [2:0] SEL_C2       = 3'd6;

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [1:0] op_q, op_d;
  logic [2:0] dest_q, dest_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] wreg_q, wreg_d;
  logic       ready_q, busy_q, done_q;
`ifdef REGSRC_SEQ_ERR_EN
  logic       err_q, err_d;
`endif

  // Step table: returns {write register, mux select} for a given op/step.
  function automatic logic [5:0] step_entry(input logic [1:0] op,
                                            input logic [2:0] step,
                                            input logic [2:0] dest);
    logic [5:0] e;
    e = '0;
    case (op)
      OP_ZERO_ALL: e = {step + 3'd1, SEL_C0};
      OP_LOAD_CONSTS: begin
        case (step)
          3'd0:    e = {3'd1, SEL_C1};
          3'd1:    e = {3'd2, SEL_C2};
          3'd2:    e = {3'd3, SEL_C3};
          3'd3:    e = {3'd6, SEL_C6};
          3'd4:    e = {3'd7, SEL_C7};
          default: e = '0;
        endcase
      end
      OP_MOVE: e = {dest, SEL_DATAPATH};
      default: e = '0;
    endcase
    return e;
  endfunction

  // Index of the final step of each op (illegal op runs as a single empty step).
  function automatic logic [2:0] last_step(input logic [1:0] op);
    logic [2:0] l;
    case (op)
      OP_ZERO_ALL:    l = 3'd6;
      OP_LOAD_CONSTS: l = 3'd4;
      default:        l = 3'd0;
    endcase
    return l;
  endfunction

  // Next-state, step sequencing and next registered output values.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    dest_d  = dest_q;
    sel_d   = '0;
    wreg_d  = '0;
`ifdef REGSRC_SEQ_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start && ready_q) begin
          op_d   = Op;
          dest_d = Dest;
          step_d = '0;
`ifdef REGSRC_SEQ_ERR_EN
          if (Op == OP_ILLEGAL) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d         = RUN;
            {wreg_d, sel_d} = step_entry(Op, 3'd0, Dest);
          end
`else
          state_d         = RUN;
          {wreg_d, sel_d} = step_entry(Op, 3'd0, Dest);
`endif
        end
      end
      RUN: begin
        if (Hold) begin
          sel_d  = sel_q;
          wreg_d = wreg_q;
        end else if (step_q == last_step(op_q)) begin
          state_d = DONE;
        end else begin
          step_d          = step_q + 3'd1;
          {wreg_d, sel_d} = step_entry(op_q, step_q + 3'd1, dest_q);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched command and registered outputs; reset clears everything.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      sel_q   <= '0;
      wreg_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      sel_q   <= sel_d;
      wreg_q  <= wreg_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

`ifdef REGSRC_SEQ_ERR_EN
  // Sticky illegal-op flag, cleared only by reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign Err = err_q;
`endif

  assign Selection = sel_q;
  assign WriteReg  = wreg_q;
  assign Ready     = ready_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  // The illegal op's empty step never writes.
  assign RegWrite  = busy_q & ~Hold & (op_q != OP_ILLEGAL);

endmodule

// File: tb/tb_reg_src_sequencer.sv
// Directed testbench for reg_src_sequencer.
module tb_reg_src_sequencer;

  logic       Clock;
  logic       Reset_n;
  logic       Start;
  logic [1:0] Op;
  logic [2:0] Dest;
  logic       Hold;
  logic [2:0] Selection;
  logic       RegWrite;
  logic [2:0] WriteReg;
  logic       Ready;
  logic       Busy;
  logic       Done;
`ifdef REGSRC_SEQ_ERR_EN
  logic       Err;
`endif

  int errors = 0;
  int checks = 0;

  reg_src_sequencer dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Op       (Op),
    .Dest     (Dest),
    .Hold     (Hold),
    .Selection(Selection),
    .RegWrite (RegWrite),
    .WriteReg (WriteReg),
    .Ready    (Ready),
    .Busy     (Busy),
    .Done     (Done)
`ifdef REGSRC_SEQ_ERR_EN
    ,
    .Err      (Err)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] dest);
    if (Ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got=%0b exp=1", Ready);
    end
    checks++;
    Op = op; Dest = dest; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; Start = 1'b0; Op = '0; Dest = '0; Hold = 1'b0;
    #12;
    if ({Selection, WriteReg, RegWrite, Busy, Done} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {Selection, WriteReg, RegWrite, Busy, Done});
    end
    checks++;
`ifdef REGSRC_SEQ_ERR_EN
    if (Err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", Err); end
    checks++;
`endif
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    tick();
    if (Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", Ready); end
    checks++;
  endtask

  task automatic test_load_consts;
    logic [2:0] ew [5] = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    logic [2:0] es [5] = '{3'd2, 3'd6, 3'd3, 3'd4, 3'd5};
    issue(2'd1, 3'd0);
    for (int k = 0; k < 5; k++) begin
      if (WriteReg !== ew[k] || Selection !== es[k] || RegWrite !== 1'b1 || Busy !== 1'b1) begin
        errors++;
        $display("FAIL load_step%0d got wr=%0d sel=%0d we=%0b busy=%0b exp wr=%0d sel=%0d we=1 busy=1",
                 k, WriteReg, Selection, RegWrite, Busy, ew[k], es[k]);
      end
      checks++;
      tick();
    end
    if (Done !== 1'b1 || Busy !== 1'b0 || RegWrite !== 1'b0 || Selection !== 3'd0 || WriteReg !== 3'd0) begin
      errors++;
      $display("FAIL load_done got done=%0b busy=%0b we=%0b sel=%0d wr=%0d exp done=1 others 0",
               Done, Busy, RegWrite, Selection, WriteReg);
    end
    checks++;
    tick();
    if (Ready !== 1'b1 || Done !== 1'b0) begin
      errors++; $display("FAIL load_ready got ready=%0b done=%0b exp ready=1 done=0", Ready, Done);
    end
    checks++;
  endtask

  task automatic test_move;
    issue(2'd2, 3'd5);
    Dest = 3'd2;
    if (WriteReg !== 3'd5 || Selection !== 3'd0 || RegWrite !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL move_step got wr=%0d sel=%0d we=%0b busy=%0b exp wr=5 sel=0 we=1 busy=1",
               WriteReg, Selection, RegWrite, Busy);
    end
    checks++;
    tick();
    if (Done !== 1'b1 || Busy !== 1'b0 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL move_done got done=%0b busy=%0b we=%0b exp 1 0 0", Done, Busy, RegWrite);
    end
    checks++;
    tick();
  endtask

  task automatic test_zero_hold;
    logic [2:0] ew [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0};
    logic       we [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int writes = 0;
    issue(2'd0, 3'd0);
    for (int c = 0; c < 10; c++) begin
      Hold = (c == 4 || c == 5);
      #1;
      if (WriteReg !== ew[c] || RegWrite !== we[c] || Done !== (c == 9)) begin
        errors++;
        $display("FAIL zero_hold_c%0d got wr=%0d we=%0b done=%0b exp wr=%0d we=%0b done=%0b",
                 c, WriteReg, RegWrite, Done, ew[c], we[c], (c == 9));
      end
      checks++;
      if (RegWrite === 1'b1) writes++;
      tick();
    end
    Hold = 1'b0;
    if (writes !== 7) begin errors++; $display("FAIL zero_hold_writes got=%0d exp=7", writes); end
    checks++;
  endtask

  task automatic test_ignore_start;
    issue(2'd2, 3'd3);
    Start = 1'b1; Op = 2'd0; Dest = 3'd6;
    #1;
    if (WriteReg !== 3'd3 || Selection !== 3'd0) begin
      errors++; $display("FAIL ignore_busy got wr=%0d sel=%0d exp wr=3 sel=0", WriteReg, Selection);
    end
    checks++;
    tick();
    if (Done !== 1'b1) begin errors++; $display("FAIL ignore_done got=%0b exp=1", Done); end
    checks++;
    Start = 1'b0;
    tick();
    if (Ready !== 1'b1 || Busy !== 1'b0) begin
      errors++; $display("FAIL ignore_after got ready=%0b busy=%0b exp ready=1 busy=0", Ready, Busy);
    end
    checks++;
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp [5] = '{4'b0100, 4'b0010, 4'b1000, 4'b0100, 4'b0010};
    Op = 2'd2; Dest = 3'd4; Start = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 3) Start = 1'b0;
      if ({Ready, Busy, Done, 1'b0} !== exp[c]) begin
        errors++;
        $display("FAIL b2b_c%0d got rbd=%b exp rbd=%b", c, {Ready, Busy, Done}, exp[c][3:1]);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_illegal;
    issue(2'd3, 3'd0);
`ifdef REGSRC_SEQ_ERR_EN
    if (Done !== 1'b1 || RegWrite !== 1'b0 || Err !== 1'b1) begin
      errors++; $display("FAIL illegal_c1 got done=%0b we=%0b err=%0b exp 1 0 1", Done, RegWrite, Err);
    end
    checks++;
    tick();
    issue(2'd2, 3'd1);
    tick();
    if (Err !== 1'b1) begin errors++; $display("FAIL illegal_sticky got=%0b exp=1", Err); end
    checks++;
    tick();
`else
    if (Busy !== 1'b1 || RegWrite !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL illegal_c1 got busy=%0b we=%0b done=%0b exp 1 0 0", Busy, RegWrite, Done);
    end
    checks++;
    tick();
    if (Done !== 1'b1 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL illegal_c2 got done=%0b we=%0b exp 1 0", Done, RegWrite);
    end
    checks++;
    tick();
`endif
  endtask

  task automatic test_reset_mid;
    int saw_done = 0;
    issue(2'd0, 3'd0);
    tick(); tick(); tick();
    if (WriteReg !== 3'd4) begin errors++; $display("FAIL mid_pre got wr=%0d exp=4", WriteReg); end
    checks++;
    Reset_n = 1'b0;
    #1;
    if ({Selection, WriteReg, RegWrite, Busy, Done} !== 9'b0) begin
      errors++;
      $display("FAIL mid_async got=%b exp=0", {Selection, WriteReg, RegWrite, Busy, Done});
    end
    checks++;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (Done === 1'b1 || RegWrite === 1'b1) saw_done++;
    end
    if (saw_done !== 0) begin errors++; $display("FAIL mid_quiet got=%0d exp=0", saw_done); end
    checks++;
    Reset_n = 1'b1;
    tick();
    issue(2'd0, 3'd0);
    if (WriteReg !== 3'd1 || Selection !== 3'd1 || RegWrite !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart got wr=%0d sel=%0d we=%0b exp wr=1 sel=1 we=1", WriteReg, Selection, RegWrite);
    end
    checks++;
    for (int c = 0; c < 8; c++) tick();
  endtask

  initial begin
    test_reset();
    test_load_consts();
    test_move();
    test_zero_hold();
    test_ignore_start();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
